// File: rtl/ifm_feeder.sv
// Producer for the 3x3 PE-array IFM buffer: loads a raster-ordered tile (5x5 conv,
// 2x4 pool) and replays it as the packed word triplets of the buffer's snake scan.
module ifm_feeder #(
    parameter int PIX_WIDTH  = 8,
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 3,
    parameter int TILE_DIM   = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [1:0]                           layer_type,
    input  logic                                 start,
    input  logic [PIX_WIDTH-1:0]                 pix_in,
    input  logic                                 pix_valid,
    output logic                                 pix_ready,
    output logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ifm_input,
    output logic                                 out_valid,
    output logic [3:0]                           step,
    output logic                                 busy,
    output logic                                 done
);

    localparam int         TILE_CELLS = TILE_DIM * TILE_DIM;
    localparam logic [4:0] CONV_LAST  = 5'(TILE_CELLS - 1);
    localparam logic [4:0] POOL_LAST  = 5'd7;
    localparam logic [3:0] LAST_STEP  = 4'd8;
    localparam logic [1:0] LT_CONV    = 2'b01;
    localparam logic [1:0] LT_POOL    = 2'b10;
    localparam logic [PIX_WIDTH-1:0] ZP = '0;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, FIN} state_e;

    state_e                                state_q, state_d;
    logic [4:0]                            cnt_q, cnt_d;
    logic [3:0]                            step_q, step_d;
    logic                                  pool_q, pool_d;
    logic [PIX_WIDTH-1:0]                  tile_q [TILE_CELLS];
    logic [PIX_WIDTH-1:0]                  tile_d [TILE_CELLS];
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]  words_q, words_d;
    logic [2:0]                            org_r, org_c;

    function automatic logic [4:0] pidx(input logic [2:0] y, input logic [2:0] x);
        return ({2'b00, y} * 5'd5) + {2'b00, x};
    endfunction

    // NOTE: sequential state uses non-blocking assignments only; all next-state
    // arithmetic lives in the combinational blocks with blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            pool_q  <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            pool_q  <= pool_d;
            words_q <= words_d;
        end
    end

    // NOTE: the tile store is plain storage that is always fully rewritten before
    // it is read, so it carries no reset and can map onto cheap registers/RAM.
    always_ff @(posedge clk) begin
        tile_q <= tile_d;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        pool_d  = pool_q;
        tile_d  = tile_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (layer_type == LT_CONV || layer_type == LT_POOL) begin
                        state_d = LOAD;
                        pool_d  = (layer_type == LT_POOL);
                        cnt_d   = '0;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            LOAD: begin
                if (pix_valid) begin
                    tile_d[cnt_q] = pix_in;
                    cnt_d         = cnt_q + 5'd1;
                    if (cnt_q == (pool_q ? POOL_LAST : CONV_LAST)) begin
                        state_d = EMIT;
                        step_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            EMIT: begin
                if (pool_q || step_q == LAST_STEP) begin
                    state_d = FIN;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The beat is built from the next-cycle tile image so the last pixel written
    // on the final LOAD cycle is already visible in the first registered beat.
    always_comb begin
        pix_ready = (state_q == LOAD);
        busy      = (state_q != IDLE);
        out_valid = (state_q == EMIT);
        done      = (state_q == FIN);
        step      = step_q;
        words_d   = '0;
        org_r     = 3'd0;
        org_c     = 3'd0;
        if (state_d == EMIT) begin
            if (pool_d) begin
                words_d[0] = {tile_d[0], tile_d[1], tile_d[2], tile_d[3]};
                words_d[1] = {tile_d[4], tile_d[5], tile_d[6], tile_d[7]};
            end else begin
                if (step_d >= 4'd6)      org_r = 3'd2;
                else if (step_d >= 4'd3) org_r = 3'd1;
                case (step_d)
                    4'd1, 4'd4, 4'd7: org_c = 3'd1;
                    4'd2, 4'd3, 4'd8: org_c = 3'd2;
                    default:          org_c = 3'd0;
                endcase
                case (step_d)
                    4'd0: begin
                        words_d[0] = {ZP, tile_d[pidx(3'd0, 3'd0)], tile_d[pidx(3'd0, 3'd1)], tile_d[pidx(3'd0, 3'd2)]};
                        words_d[1] = {ZP, tile_d[pidx(3'd1, 3'd0)], tile_d[pidx(3'd1, 3'd1)], tile_d[pidx(3'd1, 3'd2)]};
                        words_d[2] = {ZP, tile_d[pidx(3'd2, 3'd0)], tile_d[pidx(3'd2, 3'd1)], tile_d[pidx(3'd2, 3'd2)]};
                    end
                    4'd1, 4'd2, 4'd7, 4'd8:
                        words_d[0] = {ZP, tile_d[pidx(org_r, org_c + 3'd2)],
                                      tile_d[pidx(org_r + 3'd1, org_c + 3'd2)],
                                      tile_d[pidx(org_r + 3'd2, org_c + 3'd2)]};
                    4'd3, 4'd6:
                        words_d[1] = {ZP, tile_d[pidx(org_r + 3'd2, org_c)],
                                      tile_d[pidx(org_r + 3'd2, org_c + 3'd1)],
                                      tile_d[pidx(org_r + 3'd2, org_c + 3'd2)]};
                    4'd4, 4'd5:
                        words_d[2] = {ZP, tile_d[pidx(org_r, org_c)],
                                      tile_d[pidx(org_r + 3'd1, org_c)],
                                      tile_d[pidx(org_r + 3'd2, org_c)]};
                    default: ;
                endcase
            end
        end
    end

    assign ifm_input = words_q;

endmodule

// File: tb/tb_ifm_feeder.sv
// Randomised bench for ifm_feeder: the expected beats come from window-origin
// geometry of the snake scan applied to the pixels the bench streamed in.
module tb_ifm_feeder;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       layer_type;
    logic             start;
    logic [7:0]       pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic [2:0][31:0] ifm_input;
    logic             out_valid;
    logic [3:0]       step;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]       px  [25];
    logic [2:0][31:0] cap [9];

    ifm_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .layer_type(layer_type),
        .start     (start),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .ifm_input (ifm_input),
        .out_valid (out_valid),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected beat from the window origin of step s and how it moved from step s-1.
    function automatic logic [2:0][31:0] model_beat(input int s, input bit pool);
        int orow[9];
        int ocol[9];
        int r, c, dr, dc;
        logic [2:0][31:0] w;
        orow = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        ocol = '{0, 1, 2, 2, 1, 0, 0, 1, 2};
        w = '0;
        if (pool) begin
            w[0] = {px[0], px[1], px[2], px[3]};
            w[1] = {px[4], px[5], px[6], px[7]};
            return w;
        end
        r = orow[s];
        c = ocol[s];
        if (s == 0) begin
            for (int i = 0; i < 3; i++)
                w[i] = {8'h00, px[i*5], px[i*5+1], px[i*5+2]};
        end else begin
            dr = r - orow[s-1];
            dc = c - ocol[s-1];
            if (dc == 1)
                w[0] = {8'h00, px[r*5+c+2], px[(r+1)*5+c+2], px[(r+2)*5+c+2]};
            else if (dc == -1)
                w[2] = {8'h00, px[r*5+c], px[(r+1)*5+c], px[(r+2)*5+c]};
            else if (dr == 1)
                w[1] = {8'h00, px[(r+2)*5+c], px[(r+2)*5+c+1], px[(r+2)*5+c+2]};
        end
        return w;
    endfunction

    // mode: 0 back-to-back, 1 valid toggling, 2 random bubbles.
    task automatic run_tile(input logic [1:0] lt, input int mode, input bit disturb,
                            input int rst_beat, input string name);
        bit pool, real_tile, v, tog;
        int n, nb, acc, cyc;
        pool      = (lt == 2'b10);
        real_tile = (lt == 2'b01) || (lt == 2'b10);
        n         = pool ? 8 : 25;
        nb        = pool ? 1 : 9;
        @(negedge clk);
        layer_type = lt;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_start"}, 96'(busy), 96'd1);
        if (!real_tile) begin
            check({name, "_nt_ready"}, 96'(pix_ready), 96'd0);
            check({name, "_nt_valid"}, 96'(out_valid), 96'd0);
            check({name, "_nt_done"}, 96'(done), 96'd1);
            @(negedge clk);
            check({name, "_nt_done_clr"}, 96'(done), 96'd0);
            check({name, "_nt_busy_clr"}, 96'(busy), 96'd0);
            return;
        end
        acc = 0;
        cyc = 0;
        tog = 1'b1;
        while (acc < n && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = !tog; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            pix_valid = v;
            pix_in    = v ? px[acc] : 8'($urandom);
            if (v && pix_ready) acc++;
            if (disturb && acc == n / 2) layer_type = ~lt;
            @(negedge clk);
            cyc++;
        end
        if (acc < n) begin
            check({name, "_load_timeout"}, 96'(acc), 96'(n));
            pix_valid = 1'b0;
            return;
        end
        pix_valid = 1'b1;
        pix_in    = 8'hEE;
        check({name, "_ready_drop"}, 96'(pix_ready), 96'd0);
        for (int b = 0; b < nb; b++) begin
            check($sformatf("%s_valid%0d", name, b), 96'(out_valid), 96'd1);
            check($sformatf("%s_step%0d", name, b), 96'(step), 96'(b));
            check($sformatf("%s_beat%0d", name, b), 96'(ifm_input), 96'(model_beat(b, pool)));
            cap[b] = ifm_input;
            if (b == 1) pix_valid = 1'b0;
            if (rst_beat == b) begin
                rst = 1'b1;
                #1;
                check({name, "_rst_valid"}, 96'(out_valid), 96'd0);
                check({name, "_rst_words"}, 96'(ifm_input), 96'd0);
                check({name, "_rst_busy"}, 96'(busy), 96'd0);
                check({name, "_rst_ready"}, 96'(pix_ready), 96'd0);
                check({name, "_rst_step"}, 96'(step), 96'd0);
                pix_valid = 1'b0;
                start     = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (disturb && b == 2) begin
                start      = 1'b1;
                layer_type = 2'b11;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        pix_valid = 1'b0;
        check({name, "_fin_valid"}, 96'(out_valid), 96'd0);
        check({name, "_fin_words"}, 96'(ifm_input), 96'd0);
        check({name, "_fin_step"}, 96'(step), 96'd0);
        check({name, "_fin_done"}, 96'(done), 96'd1);
        check({name, "_fin_busy"}, 96'(busy), 96'd1);
        @(negedge clk);
        check({name, "_idle_done"}, 96'(done), 96'd0);
        check({name, "_idle_busy"}, 96'(busy), 96'd0);
        check({name, "_idle_ready"}, 96'(pix_ready), 96'd0);
    endtask

    task automatic randomize_px();
        for (int i = 0; i < 25; i++) px[i] = 8'($urandom);
    endtask

    task automatic check_counting_beats(input string name);
        check({name, "_b0w0"}, 96'(cap[0][0]), 96'h00010203);
        check({name, "_b0w1"}, 96'(cap[0][1]), 96'h00060708);
        check({name, "_b0w2"}, 96'(cap[0][2]), 96'h000B0C0D);
        check({name, "_b1w0"}, 96'(cap[1][0]), 96'h0004090E);
        check({name, "_b3w1"}, 96'(cap[3][1]), 96'h00121314);
        check({name, "_b4w2"}, 96'(cap[4][2]), 96'h00070C11);
        check({name, "_b8w0"}, 96'(cap[8][0]), 96'h000F1419);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pix_valid  = 1'b0;
        pix_in     = '0;
        layer_type = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_ready", 96'(pix_ready), 96'd0);
        check("reset_words", 96'(ifm_input), 96'd0);
        check("reset_valid", 96'(out_valid), 96'd0);
        check("reset_step", 96'(step), 96'd0);
        check("reset_busy", 96'(busy), 96'd0);
        check("reset_done", 96'(done), 96'd0);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) px[i] = 8'(i + 1);
        run_tile(2'b01, 0, 1'b0, -1, "conv_b2b");
        check_counting_beats("conv_b2b");
        run_tile(2'b01, 1, 1'b0, -1, "conv_tog");
        check_counting_beats("conv_tog");

        for (int i = 0; i < 8; i++) px[i] = 8'(8'hA0 + i);
        run_tile(2'b10, 0, 1'b0, -1, "pool");
        check("pool_const", 96'(cap[0]), 96'h00000000_A4A5A6A7_A0A1A2A3);

        run_tile(2'b11, 0, 1'b0, -1, "fully");
        run_tile(2'b00, 0, 1'b0, -1, "none");

        randomize_px();
        run_tile(2'b01, 2, 1'b1, -1, "conv_dist");
        randomize_px();
        run_tile(2'b10, 2, 1'b1, -1, "pool_dist");

        randomize_px();
        run_tile(2'b01, 0, 1'b0, 4, "conv_rst");
        randomize_px();
        run_tile(2'b01, 2, 1'b0, -1, "conv_after_rst");

        for (int t = 0; t < 8; t++) begin
            logic [1:0] lt;
            lt = 2'($urandom_range(0, 3));
            randomize_px();
            run_tile(lt, 2, 1'($urandom_range(0, 1)), -1, $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
